// File: rtl/hello_tx.sv
// hello_tx: fixed-message UART transmitter.
// On a start request, sends "hello world!" CR LF (14 bytes) as 8N1 frames.
// Frames follow each other with no idle gap. Bit time comes from an integer
// clock divider.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   i_start      level-sampled request, acted on only in IDLE
//   o_tx         serial line, idle high
//   o_busy       high while a message is in flight
//   o_done       one-cycle pulse when the last stop bit completes
//   o_byte_out   byte currently being framed
//   o_byte_stb   one-cycle pulse on the first cycle of each start bit
//   o_byte_idx   index 0..13 of the current byte
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | line high, waiting for i_start
// START | start bit (low) of the current byte
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (high); then next byte or back to IDLE

module hello_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_byte_out,
  output logic       o_byte_stb,
  output logic [3:0] o_byte_idx
);

  localparam int MSG_LEN = 14;
  localparam int CW      = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    IDX_LAST = 4'(MSG_LEN - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("hello_tx: CLKS_PER_BIT must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_cnt;
  logic          r_tx;
  logic          r_busy;
  logic          r_done;
  logic [7:0]    r_byte_out;
  logic          r_byte_stb;
  logic [3:0]    r_byte_idx;

  logic       w_clk_last;
  logic [2:0] w_next_bit;
  logic [3:0] w_next_idx;

  function automatic logic [7:0] msg_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h68;  // h
      4'd1:    return 8'h65;  // e
      4'd2:    return 8'h6C;  // l
      4'd3:    return 8'h6C;  // l
      4'd4:    return 8'h6F;  // o
      4'd5:    return 8'h20;  // space
      4'd6:    return 8'h77;  // w
      4'd7:    return 8'h6F;  // o
      4'd8:    return 8'h72;  // r
      4'd9:    return 8'h6C;  // l
      4'd10:   return 8'h64;  // d
      4'd11:   return 8'h21;  // !
      4'd12:   return 8'h0D;  // CR
      4'd13:   return 8'h0A;  // LF
      default: return 8'h00;
    endcase
  endfunction

  assign w_clk_last = (r_clk_cnt == CNT_LAST);
  assign w_next_bit = r_bit_cnt + 3'd1;
  assign w_next_idx = r_byte_idx + 4'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_byte_out <= 8'h00;
      r_byte_stb <= 1'b0;
      r_byte_idx <= 4'd0;
    end else begin
      // Pulses default low; each state raises them only on its transition.
      r_done     <= 1'b0;
      r_byte_stb <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (i_start) begin
            r_state    <= S_START;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_byte_idx <= 4'd0;
            r_byte_out <= msg_byte(4'd0);
            r_byte_stb <= 1'b1;
          end
        end
        S_START: begin
          if (w_clk_last) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
            r_tx      <= r_byte_out[0];
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_clk_last) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
              r_state   <= S_STOP;
              r_tx      <= 1'b1;
            end else begin
              r_bit_cnt <= w_next_bit;
              r_tx      <= r_byte_out[w_next_bit];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_clk_last) begin
            r_clk_cnt <= '0;
            if (r_byte_idx == IDX_LAST) begin
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_byte_idx <= 4'd0;
              r_tx       <= 1'b1;
            end else begin
              // Next start bit follows the stop bit directly.
              r_state    <= S_START;
              r_byte_idx <= w_next_idx;
              r_byte_out <= msg_byte(w_next_idx);
              r_byte_stb <= 1'b1;
              r_tx       <= 1'b0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx       = r_tx;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_byte_out = r_byte_out;
  assign o_byte_stb = r_byte_stb;
  assign o_byte_idx = r_byte_idx;

endmodule
